// File: rtl/icache_prefetch_ctrl.sv
// icache_prefetch_ctrl: demand-miss loader with sequential next-line prefetch, tag-keyed MSHR and HALT bound
module icache_prefetch_ctrl #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W = 4,
  parameter int LINE_BYTES = 8,
  parameter int PF_DEPTH = 4,
  parameter logic [31:0] HALT_WORD = 32'h555
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] proc2ctr_rd_addr,
  input  logic [DATA_W-1:0] cache2ctr_rd_data,
  input  logic              cache2ctr_rd_valid,
  input  logic [TAG_W-1:0]  mem2ctr_response,
  input  logic [TAG_W-1:0]  mem2ctr_tag,
  input  logic [DATA_W-1:0] mem2ctr_wr_data,
  output logic [DATA_W-1:0] ctr2proc_rd_data,
  output logic              ctr2proc_rd_valid,
  output logic [ADDR_W-1:0] ctr2cache_rd_addr,
  output logic [ADDR_W-1:0] ctr2cache_wr_addr,
  output logic [DATA_W-1:0] ctr2cache_wr_data,
  output logic              ctr2cache_wr_enable,
  output logic [ADDR_W-1:0] ctr2mem_req_addr,
  output logic [1:0]        ctr2mem_command,
  output logic              halt_pc_known,
  output logic              requesting_inst_exceed_bound
);
  localparam int NT = 2 ** TAG_W;
  localparam int CW = $clog2(PF_DEPTH + 1);
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH, STOP} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] req_addr, req_addr_nx, halt_pc;
  logic [CW-1:0] pf_count, pf_count_nx;
  logic [NT-1:0] mshr_valid, hit_req, hit_proc;
  logic [ADDR_W-1:0] mshr_addr [NT];
  logic [ADDR_W:0] next_addr;
  logic has_free, req_busy, proc_busy, beyond, req_on, accept, wraps, qual_miss, halt_seen;
  always_comb begin
    hit_req = '0;
    hit_proc = '0;
    for (int i = 1; i < NT; i++) begin
      hit_req[i] = mshr_valid[i] && mshr_addr[i] == req_addr;
      hit_proc[i] = mshr_valid[i] && mshr_addr[i] == proc2ctr_rd_addr;
    end
  end
  assign has_free = ~&mshr_valid[NT-1:1];
  assign req_busy = |hit_req;
  assign beyond = halt_pc_known && req_addr > halt_pc;
  // a prefetch line already in flight is skipped, not waited on
  assign req_on = state == DEMAND ? has_free : state == PREFETCH && has_free && !beyond && !req_busy;
  assign accept = req_on && mem2ctr_response != '0;
  assign next_addr = {1'b0, req_addr} + (ADDR_W + 1)'(LINE_BYTES);
  assign wraps = next_addr[ADDR_W];
  assign proc_busy = |hit_proc || (accept && req_addr == proc2ctr_rd_addr);
  assign qual_miss = !cache2ctr_rd_valid && !proc_busy && !(state == DEMAND && req_addr == proc2ctr_rd_addr);
  always_comb begin
    state_nx = state;
    req_addr_nx = req_addr;
    pf_count_nx = pf_count;
    if (qual_miss) begin
      state_nx = DEMAND;
      req_addr_nx = proc2ctr_rd_addr;
    end else if (state == DEMAND && accept) begin
      state_nx = wraps ? STOP : PREFETCH;
      req_addr_nx = next_addr[ADDR_W-1:0];
      pf_count_nx = '0;
    end else if (state == PREFETCH) begin
      if (beyond) state_nx = STOP;
      else if (accept || req_busy) begin
        pf_count_nx = pf_count + CW'(1);
        req_addr_nx = next_addr[ADDR_W-1:0];
        state_nx = (wraps || pf_count_nx == CW'(PF_DEPTH)) ? STOP : PREFETCH;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      req_addr <= '0;
      pf_count <= '0;
    end else begin
      state <= state_nx;
      req_addr <= req_addr_nx;
      pf_count <= pf_count_nx;
    end
  end
  // allocation of a tag wins over a same-cycle return of that tag
  always_ff @(posedge clock) begin
    for (int i = 0; i < NT; i++) begin
      if (reset) mshr_valid[i] <= 1'b0;
      else if (accept && mem2ctr_response == TAG_W'(i)) begin
        mshr_valid[i] <= 1'b1;
        mshr_addr[i] <= req_addr;
      end else if (mem2ctr_tag == TAG_W'(i)) mshr_valid[i] <= 1'b0;
    end
  end
  assign halt_seen = ctr2cache_wr_enable && (mem2ctr_wr_data[31:0] == HALT_WORD || mem2ctr_wr_data[63:32] == HALT_WORD);
  always_ff @(posedge clock) begin
    if (reset) begin
      halt_pc_known <= 1'b0;
      halt_pc <= '0;
    end else if (halt_seen && !halt_pc_known) begin
      halt_pc_known <= 1'b1;
      halt_pc <= ctr2cache_wr_addr;
    end
  end
  assign requesting_inst_exceed_bound = halt_pc_known && proc2ctr_rd_addr > halt_pc;
  assign ctr2proc_rd_data = cache2ctr_rd_data;
  assign ctr2proc_rd_valid = cache2ctr_rd_valid && !requesting_inst_exceed_bound;
  assign ctr2cache_rd_addr = proc2ctr_rd_addr;
  assign ctr2cache_wr_addr = mshr_addr[mem2ctr_tag];
  assign ctr2cache_wr_data = mem2ctr_wr_data;
  assign ctr2cache_wr_enable = mem2ctr_tag != '0 && mshr_valid[mem2ctr_tag];
  assign ctr2mem_req_addr = req_addr;
  assign ctr2mem_command = req_on ? BUS_LOAD : BUS_NONE;
endmodule

// File: tb/tb_icache_prefetch_ctrl.sv
// tb_icache_prefetch_ctrl: directed scenarios plus randomized traffic against a request-plan reference model
module tb_icache_prefetch_ctrl;
  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [31:0] HALT = 32'h555;
  logic clock = 1'b0;
  logic reset;
  logic [63:0] proc_addr, rd_data, wr_data;
  logic rd_valid;
  logic [3:0] resp, tag;
  logic [63:0] o_rd_data, o_rd_addr, o_wr_addr, o_wr_data, o_req_addr;
  logic o_rd_valid, o_wr_en, o_hk, o_exceed;
  logic [1:0] o_cmd;
  int checks = 0;
  int failures = 0;
  bit m_valid [16];
  logic [63:0] m_addr [16];
  bit m_hk;
  logic [63:0] m_hpc;
  logic [63:0] plan [$];
  bit plan_dem;
  logic [1:0] e_cmd;
  logic [63:0] e_req, e_wr_addr;
  bit e_wr_en, e_hk, e_exceed, e_rdv;

  always #5 clock = ~clock;

  icache_prefetch_ctrl dut (
    .clock(clock), .reset(reset),
    .proc2ctr_rd_addr(proc_addr), .cache2ctr_rd_data(rd_data), .cache2ctr_rd_valid(rd_valid),
    .mem2ctr_response(resp), .mem2ctr_tag(tag), .mem2ctr_wr_data(wr_data),
    .ctr2proc_rd_data(o_rd_data), .ctr2proc_rd_valid(o_rd_valid), .ctr2cache_rd_addr(o_rd_addr),
    .ctr2cache_wr_addr(o_wr_addr), .ctr2cache_wr_data(o_wr_data), .ctr2cache_wr_enable(o_wr_en),
    .ctr2mem_req_addr(o_req_addr), .ctr2mem_command(o_cmd),
    .halt_pc_known(o_hk), .requesting_inst_exceed_bound(o_exceed)
  );

  function automatic bit inflight(input logic [63:0] x);
    for (int i = 1; i < 16; i++) if (m_valid[i] && m_addr[i] == x) return 1'b1;
    return 1'b0;
  endfunction

  // Model: a miss plans the demand line plus up to four following lines; the head of the plan is the next request.
  task automatic drive(input logic [63:0] a, input bit rdv, input logic [3:0] rs, input logic [3:0] tg,
                       input logic [63:0] d, input bit rst);
    logic [63:0] head;
    logic [64:0] s;
    bit full, load, pop, clr, acc, busy, redir;
    @(negedge clock);
    reset = rst; proc_addr = a; rd_valid = rdv; resp = rs; tag = tg; wr_data = d;
    rd_data = {$urandom, $urandom};
    #1;
    full = 1'b1;
    for (int i = 1; i < 16; i++) if (!m_valid[i]) full = 1'b0;
    head = plan.size() > 0 ? plan[0] : 64'h0;
    load = 0; pop = 0; clr = 0;
    if (plan.size() > 0) begin
      if (plan_dem) load = !full;
      else if (m_hk && head > m_hpc) clr = 1;
      else if (inflight(head)) pop = 1;
      else load = !full;
    end
    acc = load && rs != 0;
    if (acc) pop = 1;
    busy = inflight(a) || (acc && head == a);
    redir = !rdv && !busy && !(plan_dem && head == a);
    e_cmd = load ? LOAD : NONE;
    e_req = head;
    e_exceed = m_hk && a > m_hpc;
    e_rdv = rdv && !e_exceed;
    e_hk = m_hk;
    e_wr_en = tg != 0 && m_valid[tg];
    e_wr_addr = m_addr[tg];
    if (rst) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
      plan.delete(); plan_dem = 0; m_hk = 0; m_hpc = 0;
    end else begin
      if (e_wr_en && !m_hk && (d[31:0] == HALT || d[63:32] == HALT)) begin
        m_hk = 1; m_hpc = m_addr[tg];
      end
      if (tg != 0) m_valid[tg] = 0;
      if (acc) begin m_valid[rs] = 1; m_addr[rs] = head; end
      if (redir) begin
        plan.delete(); plan.push_back(a); plan_dem = 1;
        for (int k = 1; k <= 4; k++) begin
          s = {1'b0, a} + 65'(8 * k);
          if (s[64]) break;
          plan.push_back(s[63:0]);
        end
      end else if (clr) begin plan.delete(); plan_dem = 0; end
      else if (pop) begin void'(plan.pop_front()); plan_dem = 0; end
    end
  endtask

  task automatic test_reset();
    drive(0, 1, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1);
    checks++; if (o_cmd !== NONE) begin failures++; $display("FAIL reset_cmd got=%0d exp=%0d", o_cmd, NONE); end
    checks++; if (o_hk !== 1'b0) begin failures++; $display("FAIL reset_halt_known got=%b exp=0", o_hk); end
    drive(0, 1, 0, 4'd5, 64'h555, 0);
    checks++; if (o_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", o_wr_en); end
    checks++; if (o_exceed !== 1'b0 || o_rd_valid !== 1'b1) begin failures++; $display("FAIL reset_rd exceed=%b rdv=%b exp 0 1", o_exceed, o_rd_valid); end
  endtask

  task automatic test_demand_prefetch();
    drive(64'h100, 0, 0, 0, 0, 0);
    checks++; if (o_cmd !== NONE) begin failures++; $display("FAIL t1_idle_cmd got=%0d exp=0", o_cmd); end
    for (int k = 0; k < 5; k++) begin
      drive(64'h100, 0, 4'(3 + k), 0, 0, 0);
      checks++;
      if (o_cmd !== LOAD || o_req_addr !== 64'h100 + 64'(8 * k)) begin
        failures++; $display("FAIL t1_req%0d cmd=%0d addr=%h exp=1 %h", k, o_cmd, o_req_addr, 64'h100 + 64'(8 * k));
      end
    end
    for (int k = 0; k < 2; k++) begin
      drive(64'h100, 0, 4'd8, 0, 0, 0);
      checks++; if (o_cmd !== NONE) begin failures++; $display("FAIL t1_stop_cmd got=%0d exp=0", o_cmd); end
    end
  endtask

  task automatic test_halt();
    logic [3:0] tg [4] = '{4'd3, 4'd4, 4'd5, 4'd7};
    logic [63:0] ad [4] = '{64'h100, 64'h108, 64'h110, 64'h120};
    drive(64'h100, 1, 0, 4'd6, 64'h0000055500000000, 0);
    checks++;
    if (o_wr_en !== 1'b1 || o_wr_addr !== 64'h118 || o_wr_data !== 64'h0000055500000000 || o_hk !== 1'b0) begin
      failures++; $display("FAIL t3_halt_write en=%b addr=%h data=%h hk=%b exp 1 118 0000055500000000 0", o_wr_en, o_wr_addr, o_wr_data, o_hk);
    end
    drive(64'h120, 1, 0, 0, 0, 0);
    checks++;
    if (o_hk !== 1'b1 || o_exceed !== 1'b1 || o_rd_valid !== 1'b0) begin
      failures++; $display("FAIL t3_bound_over hk=%b exceed=%b rdv=%b exp 1 1 0", o_hk, o_exceed, o_rd_valid);
    end
    drive(64'h118, 1, 0, 0, 0, 0);
    checks++; if (o_exceed !== 1'b0 || o_rd_valid !== 1'b1) begin failures++; $display("FAIL t3_bound_at exceed=%b rdv=%b exp 0 1", o_exceed, o_rd_valid); end
    for (int i = 0; i < 4; i++) begin
      drive(64'h118, 1, 0, tg[i], 64'h0, 0);
      checks++;
      if (o_wr_en !== 1'b1 || o_wr_addr !== ad[i]) begin failures++; $display("FAIL t3_return%0d en=%b addr=%h exp 1 %h", i, o_wr_en, o_wr_addr, ad[i]); end
    end
    drive(64'h108, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(64'h108, 0, 4'(1 + k), 0, 0, 0);
      checks++;
      if (o_cmd !== LOAD || o_req_addr !== 64'h108 + 64'(8 * k)) begin
        failures++; $display("FAIL t3_req%0d cmd=%0d addr=%h exp=1 %h", k, o_cmd, o_req_addr, 64'h108 + 64'(8 * k));
      end
    end
    for (int k = 0; k < 2; k++) begin
      drive(64'h108, 0, 4'd9, 0, 0, 0);
      checks++; if (o_cmd !== NONE) begin failures++; $display("FAIL t3_no_pf_past_halt got=%0d exp=0", o_cmd); end
    end
    drive(64'h108, 1, 0, 4'd1, 64'h0000000000000555, 0);
    drive(64'h120, 1, 0, 0, 0, 0);
    checks++; if (o_exceed !== 1'b1) begin failures++; $display("FAIL t3_second_halt_ignored exceed=%b exp=1", o_exceed); end
  endtask

  task automatic test_retry_redirect();
    drive(0, 1, 0, 0, 0, 1);
    drive(64'h200, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      drive(64'h200, 0, k == 5 ? 4'd1 : 4'd0, 0, 0, 0);
      checks++; if (o_cmd !== LOAD || o_req_addr !== 64'h200) begin failures++; $display("FAIL t2_hold%0d cmd=%0d addr=%h exp=1 200", k, o_cmd, o_req_addr); end
    end
    drive(64'h200, 0, 4'd2, 0, 0, 0);
    checks++; if (o_cmd !== LOAD || o_req_addr !== 64'h208) begin failures++; $display("FAIL t4_pf cmd=%0d addr=%h exp=1 208", o_cmd, o_req_addr); end
    drive(64'h400, 0, 0, 0, 0, 0);
    checks++; if (o_cmd !== LOAD || o_req_addr !== 64'h210) begin failures++; $display("FAIL t4_pending cmd=%0d addr=%h exp=1 210", o_cmd, o_req_addr); end
    drive(64'h400, 0, 0, 4'd2, 64'h0, 0);
    checks++; if (o_cmd !== LOAD || o_req_addr !== 64'h400) begin failures++; $display("FAIL t4_redirect cmd=%0d addr=%h exp=1 400", o_cmd, o_req_addr); end
    checks++; if (o_wr_en !== 1'b1 || o_wr_addr !== 64'h208) begin failures++; $display("FAIL t4_old_pf_write en=%b addr=%h exp 1 208", o_wr_en, o_wr_addr); end
    drive(64'h400, 0, 4'd3, 0, 0, 0);
    drive(64'h400, 0, 4'd4, 0, 0, 0);
    checks++; if (o_cmd !== LOAD || o_req_addr !== 64'h408) begin failures++; $display("FAIL t5_no_dup_demand cmd=%0d addr=%h exp=1 408", o_cmd, o_req_addr); end
    drive(64'h400, 0, 0, 4'd1, 64'h0, 0);
    checks++; if (o_wr_en !== 1'b1 || o_wr_addr !== 64'h200) begin failures++; $display("FAIL t4_demand_write en=%b addr=%h exp 1 200", o_wr_en, o_wr_addr); end
    for (int k = 0; k < 3; k++) drive(64'h400, 0, 4'(5 + k), 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(64'h408, 0, 0, 0, 0, 0);
      checks++; if (o_cmd !== NONE) begin failures++; $display("FAIL t5_inflight_miss got=%0d exp=0", o_cmd); end
    end
  endtask

  task automatic test_mshr_full();
    logic [63:0] base;
    drive(0, 1, 0, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      base = 64'h1000 * 64'(c + 1);
      drive(base, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) drive(base, 0, 4'(5 * c + k + 1), 0, 0, 0);
    end
    for (int k = 0; k < 4; k++) begin
      drive(64'h4000, 0, 4'd1, 0, 0, 0);
      checks++; if (o_cmd !== NONE) begin failures++; $display("FAIL t5_full%0d got=%0d exp=0", k, o_cmd); end
    end
    drive(64'h4000, 0, 0, 4'd9, 64'h0, 0);
    checks++; if (o_cmd !== NONE || o_wr_addr !== 64'h2018) begin failures++; $display("FAIL t5_return_cycle cmd=%0d wr_addr=%h exp 0 2018", o_cmd, o_wr_addr); end
    drive(64'h4000, 0, 4'd9, 0, 0, 0);
    checks++; if (o_cmd !== LOAD || o_req_addr !== 64'h4000) begin failures++; $display("FAIL t5_freed cmd=%0d addr=%h exp=1 4000", o_cmd, o_req_addr); end
  endtask

  task automatic test_reset_outstanding();
    drive(0, 1, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1);
    for (int t = 1; t <= 3; t++) begin
      drive(0, 1, 0, 4'(t), 64'h0000055500000555, 0);
      checks++; if (o_wr_en !== 1'b0) begin failures++; $display("FAIL t6_stale_tag%0d en=%b exp=0", t, o_wr_en); end
    end
    drive(0, 1, 0, 0, 0, 0);
    checks++; if (o_hk !== 1'b0) begin failures++; $display("FAIL t6_halt_known got=%b exp=0", o_hk); end
  endtask

  task automatic test_wrap();
    drive(0, 1, 0, 0, 0, 1);
    drive(64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 0, 0, 0);
    drive(64'hFFFF_FFFF_FFFF_FFF0, 0, 4'd1, 0, 0, 0);
    drive(64'hFFFF_FFFF_FFFF_FFF0, 0, 4'd2, 0, 0, 0);
    checks++; if (o_cmd !== LOAD || o_req_addr !== 64'hFFFF_FFFF_FFFF_FFF8) begin failures++; $display("FAIL wrap_last cmd=%0d addr=%h exp=1 fffffffffffffff8", o_cmd, o_req_addr); end
    for (int k = 0; k < 2; k++) begin
      drive(64'hFFFF_FFFF_FFFF_FFF0, 0, 4'd3, 0, 0, 0);
      checks++; if (o_cmd !== NONE) begin failures++; $display("FAIL wrap_stop got=%0d exp=0 addr=%h", o_cmd, o_req_addr); end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, d;
    logic [3:0] rs, tg, st;
    bit rdv;
    a = 64'h8000;
    for (int n = 0; n < 4000; n++) begin
      if (n % 800 == 0) drive(a, 1, 0, 0, 0, 1);
      if ($urandom_range(0, 3) == 0) a = 64'h8000 + 64'(8 * $urandom_range(0, 23));
      rdv = $urandom_range(0, 2) == 0;
      tg = 0;
      if ($urandom_range(0, 3) == 0) begin
        st = 4'($urandom_range(1, 15));
        tg = st;
        for (int i = 0; i < 15; i++) if (m_valid[4'((int'(st) - 1 + i) % 15 + 1)]) begin tg = 4'((int'(st) - 1 + i) % 15 + 1); break; end
      end
      rs = 0;
      if ($urandom_range(0, 2) != 0) begin
        st = 4'($urandom_range(1, 15));
        rs = st;
        for (int i = 0; i < 15; i++) if (!m_valid[4'((int'(st) - 1 + i) % 15 + 1)]) begin rs = 4'((int'(st) - 1 + i) % 15 + 1); break; end
        if (tg != 0 && $urandom_range(0, 5) == 0) rs = tg;
      end
      d = {$urandom, $urandom};
      if ($urandom_range(0, 59) == 0) d[31:0] = HALT;
      if ($urandom_range(0, 59) == 0) d[63:32] = HALT;
      drive(a, rdv, rs, tg, d, 0);
      checks++; if (o_cmd !== e_cmd) begin failures++; $display("FAIL rnd_cmd n=%0d got=%0d exp=%0d", n, o_cmd, e_cmd); end
      if (e_cmd == LOAD) begin
        checks++; if (o_req_addr !== e_req) begin failures++; $display("FAIL rnd_req_addr n=%0d got=%h exp=%h", n, o_req_addr, e_req); end
      end
      checks++; if (o_wr_en !== e_wr_en) begin failures++; $display("FAIL rnd_wr_en n=%0d got=%b exp=%b", n, o_wr_en, e_wr_en); end
      if (e_wr_en) begin
        checks++; if (o_wr_addr !== e_wr_addr) begin failures++; $display("FAIL rnd_wr_addr n=%0d got=%h exp=%h", n, o_wr_addr, e_wr_addr); end
      end
      checks++; if (o_wr_data !== d) begin failures++; $display("FAIL rnd_wr_data n=%0d got=%h exp=%h", n, o_wr_data, d); end
      checks++; if (o_hk !== e_hk) begin failures++; $display("FAIL rnd_halt_known n=%0d got=%b exp=%b", n, o_hk, e_hk); end
      checks++; if (o_exceed !== e_exceed) begin failures++; $display("FAIL rnd_exceed n=%0d got=%b exp=%b", n, o_exceed, e_exceed); end
      checks++; if (o_rd_valid !== e_rdv) begin failures++; $display("FAIL rnd_rd_valid n=%0d got=%b exp=%b", n, o_rd_valid, e_rdv); end
      checks++; if (o_rd_addr !== a || o_rd_data !== rd_data) begin failures++; $display("FAIL rnd_passthru n=%0d addr=%h data=%h exp %h %h", n, o_rd_addr, o_rd_data, a, rd_data); end
    end
  endtask

  initial begin
    reset = 1; proc_addr = 0; rd_valid = 1; rd_data = 0; resp = 0; tag = 0; wr_data = 0;
    test_reset();
    test_demand_prefetch();
    test_halt();
    test_retry_redirect();
    test_mshr_full();
    test_reset_outstanding();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
